// File: rtl/lcd_pkg.sv
// Shared types and command constants for the 16x2 character LCD refresh controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ADDR1 = 3'd1,
    S_LINE1 = 3'd2,
    S_ADDR2 = 3'd3,
    S_LINE2 = 3'd4,
    S_HOST  = 3'd5
  } state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0E;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] ADDR_LINE1   = 8'h80;
  localparam logic [7:0] ADDR_LINE2   = 8'hC0;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;
  localparam logic [2:0] INIT_LAST    = 3'd4;

  // Clear and home need the extended execution time on the panel.
  function automatic logic is_long_cmd(input logic [7:0] b);
    return (b == CMD_CLEAR) || (b == CMD_HOME);
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    logic [7:0] c;
    case (i)
      3'd0:    c = CMD_FUNC_SET;
      3'd1:    c = CMD_DISP_ON;
      3'd2:    c = CMD_ENTRY;
      3'd3:    c = CMD_HOME;
      default: c = CMD_CLEAR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write transaction: setup, enable pulse and hold, with optional long hold.
module lcd_bus_cycle #(
  parameter int T_SETUP = 200,
  parameter int T_EN    = 1600,
  parameter int T_HOLD  = 200,
  parameter int T_LONG  = 16000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs_in,
  input  logic [7:0] byte_in,
  input  logic       long_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  localparam int TOTAL = T_SETUP + T_EN + T_HOLD;
  localparam int CW    = $clog2(TOTAL + T_LONG + 1);
  localparam logic [CW-1:0] EN_ON  = CW'(T_SETUP);
  localparam logic [CW-1:0] EN_OFF = CW'(T_SETUP + T_EN);
  localparam logic [CW-1:0] LAST_S = CW'(TOTAL - 1);
  localparam logic [CW-1:0] LAST_L = CW'(TOTAL + T_LONG - 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          long_q, long_d;
  logic          accept;

  assign done = busy_q && (cnt_q == (long_q ? LAST_L : LAST_S));

  // A start presented in the done cycle chains the next byte with no idle gap.
  always_comb begin
    accept = start && (!busy_q || done);
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rs_d   = rs_q;
    data_d = data_q;
    long_d = long_q;
    if (accept) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rs_d   = rs_in;
      data_d = byte_in;
      long_d = long_in;
    end else if (busy_q) begin
      cnt_d = cnt_q + CW'(1);
      if (done) busy_d = 1'b0;
    end
    en_d = busy_d && (cnt_d >= EN_ON) && (cnt_d < EN_OFF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      long_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      rs_q   <= rs_d;
      data_q <= data_d;
      long_q <= long_d;
    end
  end

  assign busy     = busy_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// Runs the LCD init list, then refreshes both lines from a shadow frame,
// interleaving host command bytes at byte boundaries.
module lcd_refresh_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 200,
  parameter int T_EN    = 1600,
  parameter int T_HOLD  = 200,
  parameter int T_LONG  = 16000
) (
  input  logic         LCDCLK,
  input  logic         PRESETn,
  input  logic [255:0] data,
  input  logic         data_upd,
  input  logic         cmd_req,
  input  logic [7:0]   cmd_byte,
  output logic         cmd_ack,
  output logic         init_done,
  output logic         frame_done,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic         LCD_EN,
  output logic [7:0]   LCD_DATA
);

  state_t       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic         init_done_q, init_done_d;
  logic         pend_q, pend_d;
  logic         entry_q, entry_d;
  logic [255:0] shadow_q, shadow_d;

  logic         host_ok;
  logic         bus_start, bus_rs, bus_long, bus_busy, bus_done;
  logic [7:0]   bus_byte;
  logic [7:0]   shadow_base;

  // State and index always describe the transaction currently on the bus.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    frame_done  = 1'b0;
    cmd_ack     = 1'b0;
    host_ok     = 1'b0;
    if (bus_done) begin
      case (state_q)
        S_INIT: begin
          if (idx_q == {1'b0, INIT_LAST}) begin
            init_done_d = 1'b1;
            state_d     = S_ADDR1;
            idx_d       = '0;
            host_ok     = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        S_ADDR1: begin
          state_d = S_LINE1;
          idx_d   = '0;
          host_ok = 1'b1;
        end
        S_LINE1: begin
          host_ok = 1'b1;
          if (idx_q == 4'd15) begin
            state_d = S_ADDR2;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        S_ADDR2: begin
          state_d = S_LINE2;
          idx_d   = '0;
          host_ok = 1'b1;
        end
        S_LINE2: begin
          // The frame-end boundary belongs to frame_done; a waiting host command goes after 0x80.
          if (idx_q == 4'd15) begin
            frame_done = 1'b1;
            state_d    = S_ADDR1;
            idx_d      = '0;
          end else begin
            idx_d   = idx_q + 4'd1;
            host_ok = 1'b1;
          end
        end
        S_HOST: begin
          state_d = S_ADDR1;
          idx_d   = '0;
          host_ok = 1'b1;
        end
        default: begin
          state_d = S_INIT;
          idx_d   = '0;
        end
      endcase
      if (host_ok && cmd_req) begin
        cmd_ack = 1'b1;
        state_d = S_HOST;
        idx_d   = '0;
      end
    end
  end

  // Byte to launch is taken from the next state so it can start in the done cycle.
  always_comb begin
    bus_rs      = 1'b0;
    bus_byte    = 8'h00;
    shadow_base = {state_d == S_LINE1, ~idx_d, 3'b000};
    case (state_d)
      S_INIT:  bus_byte = init_cmd(idx_d[2:0]);
      S_ADDR1: bus_byte = ADDR_LINE1;
      S_ADDR2: bus_byte = ADDR_LINE2;
      S_LINE1, S_LINE2: begin
        bus_rs   = 1'b1;
        bus_byte = shadow_q[shadow_base +: 8];
      end
      S_HOST:  bus_byte = cmd_byte;
      default: bus_byte = 8'h00;
    endcase
    bus_long  = !bus_rs && is_long_cmd(bus_byte);
    bus_start = !bus_busy || bus_done;
  end

  always_comb begin
    entry_d  = (state_d == S_ADDR1) && (state_q != S_ADDR1);
    pend_d   = pend_q | data_upd;
    shadow_d = shadow_q;
    if (entry_q) begin
      pend_d = 1'b0;
      if (pend_q || data_upd) shadow_d = data;
    end
  end

  always_ff @(posedge LCDCLK) begin
    if (!PRESETn) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      pend_q      <= 1'b0;
      entry_q     <= 1'b0;
      shadow_q    <= {32{CHAR_SPACE}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      pend_q      <= pend_d;
      entry_q     <= entry_d;
      shadow_q    <= shadow_d;
    end
  end

  assign init_done = init_done_q;

  lcd_bus_cycle #(
    .T_SETUP(T_SETUP),
    .T_EN   (T_EN),
    .T_HOLD (T_HOLD),
    .T_LONG (T_LONG)
  ) u_bus (
    .clk     (LCDCLK),
    .rst_n   (PRESETn),
    .start   (bus_start),
    .rs_in   (bus_rs),
    .byte_in (bus_byte),
    .long_in (bus_long),
    .lcd_rs  (LCD_RS),
    .lcd_rw  (LCD_RW),
    .lcd_en  (LCD_EN),
    .lcd_data(LCD_DATA),
    .busy    (bus_busy),
    .done    (bus_done)
  );

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl: expected bus transactions in a table plus hand-timed corner cases.
module tb_lcd_refresh_ctrl;

  logic         clk = 1'b0;
  logic         presetn;
  logic [255:0] data;
  logic         data_upd;
  logic         cmd_req;
  logic [7:0]   cmd_byte;
  logic         cmd_ack, init_done, frame_done;
  logic         lcd_rs, lcd_rw, lcd_en;
  logic [7:0]   lcd_data;

  always #5 clk = ~clk;

  lcd_refresh_ctrl #(
    .T_SETUP(2), .T_EN(4), .T_HOLD(2), .T_LONG(8)
  ) dut (
    .LCDCLK    (clk),
    .PRESETn   (presetn),
    .data      (data),
    .data_upd  (data_upd),
    .cmd_req   (cmd_req),
    .cmd_byte  (cmd_byte),
    .cmd_ack   (cmd_ack),
    .init_done (init_done),
    .frame_done(frame_done),
    .LCD_RS    (lcd_rs),
    .LCD_RW    (lcd_rw),
    .LCD_EN    (lcd_en),
    .LCD_DATA  (lcd_data)
  );

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         per;
  } vec_t;

  vec_t exp_tab[128];
  int   exp_n = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  // Bus monitor: cycle stamps at EN rise, EN width, ack/frame_done/init_done timing.
  int         cyc = 0;
  int         n_rise = 0;
  int         en_cnt = 0;
  logic       en_prev = 1'b0;
  logic       rec_rs[512];
  logic [7:0] rec_d[512];
  int         rec_t[512];
  int         rec_w[512];
  int         ack_t[8];
  int         n_ack = 0;
  int         fd_t[8];
  int         n_fd = 0;
  int         init_t = -1;
  logic       init_seen = 1'b0;
  int         rw_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    en_prev <= lcd_en;
    if (lcd_en && !en_prev) begin
      if (n_rise < 512) begin
        rec_rs[n_rise] <= lcd_rs;
        rec_d[n_rise]  <= lcd_data;
        rec_t[n_rise]  <= cyc;
      end
      n_rise <= n_rise + 1;
      en_cnt <= 1;
    end else if (lcd_en) begin
      en_cnt <= en_cnt + 1;
    end else if (en_prev && n_rise > 0 && n_rise <= 512) begin
      rec_w[n_rise-1] <= en_cnt;
    end
    if (cmd_ack) begin
      if (n_ack < 8) ack_t[n_ack] <= cyc;
      n_ack <= n_ack + 1;
    end
    if (frame_done) begin
      if (n_fd < 8) fd_t[n_fd] <= cyc;
      n_fd <= n_fd + 1;
    end
    if (init_done && !init_seen && presetn) begin
      init_t    <= cyc;
      init_seen <= 1'b1;
    end
    if (lcd_rw) rw_hi <= rw_hi + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic wait_rises(input int n, input int budget);
    int b = 0;
    while (n_rise < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (n_rise < n) timeout("wait_rises");
  endtask

  task automatic wait_ack(input int budget, output logic got_it);
    int b = 0;
    got_it = 1'b0;
    while (!got_it && b < budget) begin
      @(negedge clk);
      if (cmd_ack === 1'b1) got_it = 1'b1;
      b++;
    end
    if (!got_it) timeout("wait_ack");
  endtask

  task automatic add(input logic rs, input logic [7:0] d, input int per);
    exp_tab[exp_n].rs  = rs;
    exp_tab[exp_n].d   = d;
    exp_tab[exp_n].per = per;
    exp_n++;
  endtask

  task automatic add_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] step);
    add(1'b0, 8'h80, 8);
    for (int c = 0; c < 16; c++) add(1'b1, b1 + 8'(c) * step, 8);
    add(1'b0, 8'hC0, 8);
    for (int c = 0; c < 16; c++) add(1'b1, b2 + 8'(c) * step, 8);
  endtask

  function automatic logic [255:0] mk_frame(input logic [7:0] b1, input logic [7:0] b2,
                                            input logic [7:0] step);
    logic [255:0] v;
    v = '0;
    for (int c = 0; c < 16; c++) begin
      v[255-8*c -: 8] = b1 + 8'(c) * step;
      v[127-8*c -: 8] = b2 + 8'(c) * step;
    end
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got;
    int   base;
    int   b;

    // Continuous stream: init, early host cmd, frame A/B, partial frame cut by clear,
    // frame A/B (old data), frame with the pattern present at the latch point.
    add(1'b0, 8'h38, 8);  add(1'b0, 8'h0E, 8);  add(1'b0, 8'h06, 8);
    add(1'b0, 8'h02, 16); add(1'b0, 8'h01, 16); add(1'b0, 8'h0C, 8);
    add_frame(8'h41, 8'h42, 8'h00);
    add(1'b0, 8'h80, 8);
    for (int c = 0; c < 6; c++) add(1'b1, 8'h41, 8);
    add(1'b0, 8'h01, 16);
    add_frame(8'h41, 8'h42, 8'h00);
    add_frame(8'h60, 8'h70, 8'h01);

    presetn  = 1'b0;
    data     = '0;
    data_upd = 1'b0;
    cmd_req  = 1'b0;
    cmd_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_en",   32'(lcd_en),     32'd0);
    check("rst_rs",   32'(lcd_rs),     32'd0);
    check("rst_data", 32'(lcd_data),   32'd0);
    check("rst_rw",   32'(lcd_rw),     32'd0);
    check("rst_init", 32'(init_done),  32'd0);
    check("rst_ack",  32'(cmd_ack),    32'd0);
    check("rst_fd",   32'(frame_done), 32'd0);

    presetn = 1'b1;
    @(negedge clk);
    cmd_byte = 8'h0C;
    cmd_req  = 1'b1;
    repeat (3) @(negedge clk);
    data     = mk_frame(8'h41, 8'h42, 8'h00);
    data_upd = 1'b1;
    @(negedge clk);
    data_upd = 1'b0;

    wait_ack(400, got);
    check("ack1_before_init_done", 32'(init_done), 32'd0);
    @(negedge clk);
    cmd_req = 1'b0;

    wait_rises(47, 2000);
    cmd_byte = 8'h01;
    cmd_req  = 1'b1;
    wait_ack(100, got);
    @(negedge clk);
    cmd_req = 1'b0;

    wait_rises(69, 2000);
    data     = mk_frame(8'h55, 8'h55, 8'h00);
    data_upd = 1'b1;
    @(negedge clk);
    data_upd = 1'b0;
    wait_rises(73, 500);
    data_upd = 1'b1;
    @(negedge clk);
    data_upd = 1'b0;
    wait_rises(76, 500);
    data = mk_frame(8'h60, 8'h70, 8'h01);

    wait_rises(117, 2000);
    repeat (2) @(negedge clk);

    for (int i = 0; i < exp_n; i++) begin
      $display("txn %0d rs=%0d data=%02h en_w=%0d t=%0d", i, rec_rs[i], rec_d[i], rec_w[i], rec_t[i]);
      check($sformatf("txn%0d_rs", i),   32'(rec_rs[i]), 32'(exp_tab[i].rs));
      check($sformatf("txn%0d_data", i), 32'(rec_d[i]),  32'(exp_tab[i].d));
      check($sformatf("txn%0d_enw", i),  32'(rec_w[i]),  32'd4);
      if (i < exp_n - 1)
        check($sformatf("txn%0d_period", i), 32'(rec_t[i+1] - rec_t[i]), 32'(exp_tab[i].per));
    end

    check("ack_count",     32'(n_ack),    32'd2);
    check("ack1_time",     32'(ack_t[0]), 32'(rec_t[4] + 13));
    check("ack2_time",     32'(ack_t[1]), 32'(rec_t[46] + 5));
    check("init_done_t",   32'(init_t),   32'(rec_t[4] + 14));
    check("fd_count",      32'(n_fd),     32'd3);
    check("fd1_time",      32'(fd_t[0]),  32'(rec_t[39] + 5));
    check("fd2_time",      32'(fd_t[1]),  32'(rec_t[81] + 5));
    check("fd3_time",      32'(fd_t[2]),  32'(rec_t[115] + 5));
    check("rw_never_high", 32'(rw_hi),    32'd0);

    // Reset pulse in the middle of an enable strobe.
    b = 0;
    while (lcd_en !== 1'b1 && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (lcd_en !== 1'b1) timeout("wait_en_high");
    @(negedge clk);
    presetn = 1'b0;
    base = n_rise;
    @(negedge clk);
    check("abort_en",   32'(lcd_en),    32'd0);
    check("abort_rs",   32'(lcd_rs),    32'd0);
    check("abort_data", 32'(lcd_data),  32'd0);
    check("abort_init", 32'(init_done), 32'd0);
    presetn = 1'b1;

    wait_rises(base + 6, 500);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      $display("txn r%0d rs=%0d data=%02h en_w=%0d", i, rec_rs[base+i], rec_d[base+i], rec_w[base+i]);
      check($sformatf("reinit%0d_rs", i),     32'(rec_rs[base+i]), 32'd0);
      check($sformatf("reinit%0d_data", i),   32'(rec_d[base+i]),  32'(exp_tab[i].d));
      check($sformatf("reinit%0d_period", i),
            32'(rec_t[base+i+1] - rec_t[base+i]), 32'(exp_tab[i].per));
    end
    check("reinit_init_done", 32'(init_done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
